// File: rtl/debounce_bank.sv
// ============================================================================
// debounce_bank : N_CH-channel 2-FF synchroniser + stability-counter debouncer
//                 with level, rise/fall pulses and busy flags.
// Optional auto-repeat pulses on rpt when AUTOREPEAT_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module debounce_bank #(
  parameter int N_CH          = 4,
  parameter int DB_CYCLES     = 100000,
  parameter int CNT_W         = $clog2(DB_CYCLES + 1),
  parameter bit INIT_LEVEL    = 1'b0,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] undeb,
  output logic [N_CH-1:0] deb,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] busy,
  output logic [N_CH-1:0] rpt
);

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DB_CYCLES - 1);

`ifdef AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] c_rpt_first = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] c_rpt_next  = RPT_W'(REPEAT_PERIOD - 1);
`endif

  logic [N_CH-1:0] r_s1;
  logic [N_CH-1:0] r_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= {N_CH{INIT_LEVEL}};
      r_s2 <= {N_CH{INIT_LEVEL}};
    end else begin
      r_s1 <= undeb;
      r_s2 <= r_s1;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;
    logic             r_deb;
    logic             r_rise;
    logic             r_fall;
    logic             w_accept;

    // A new level is taken on the DB_CYCLES-th consecutive mismatching sample.
    assign w_accept = (r_s2[i] != r_deb) && (r_cnt == c_cnt_last);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt  <= '0;
        r_deb  <= INIT_LEVEL;
        r_rise <= 1'b0;
        r_fall <= 1'b0;
      end else begin
        r_rise <= 1'b0;
        r_fall <= 1'b0;
        if (r_s2[i] == r_deb) begin
          r_cnt <= '0;
        end else if (w_accept) begin
          r_cnt  <= '0;
          r_deb  <= r_s2[i];
          r_rise <= r_s2[i];
          r_fall <= ~r_s2[i];
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign deb[i]  = r_deb;
    assign rise[i] = r_rise;
    assign fall[i] = r_fall;
    assign busy[i] = (r_cnt != '0);

`ifdef AUTOREPEAT_EN
    logic [RPT_W-1:0] r_rcnt;
    logic             r_armed;
    logic             r_rpt;

    // Countdown to the next repeat; armed only between an accepted rise and fall.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rcnt  <= '0;
        r_armed <= 1'b0;
        r_rpt   <= 1'b0;
      end else if (w_accept && r_s2[i]) begin
        r_rcnt  <= c_rpt_first;
        r_armed <= 1'b1;
        r_rpt   <= 1'b0;
      end else if (w_accept) begin
        r_rcnt  <= '0;
        r_armed <= 1'b0;
        r_rpt   <= 1'b0;
      end else if (r_armed) begin
        if (r_rcnt == '0) begin
          r_rpt  <= 1'b1;
          r_rcnt <= c_rpt_next;
        end else begin
          r_rpt  <= 1'b0;
          r_rcnt <= r_rcnt - 1'b1;
        end
      end else begin
        r_rpt <= 1'b0;
      end
    end

    assign rpt[i] = r_rpt;
`else
    assign rpt[i] = 1'b0;
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_debounce_bank.sv
// ============================================================================
// tb_debounce_bank : directed self-checking bench for debounce_bank
//                    (window-based reference model, AUTOREPEAT_EN aware).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_debounce_bank;

  localparam int N  = 4;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] undeb = '0;
  logic [N-1:0] deb, rise, fall, busy, rpt;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  debounce_bank #(
    .N_CH(N), .DB_CYCLES(DB), .INIT_LEVEL(1'b0),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .undeb(undeb),
    .deb(deb), .rise(rise), .fall(fall), .busy(busy), .rpt(rpt)
  );

  // Reference: the level flips when the last DB synchronised samples
  // (raw samples delayed by two edges) all disagree with it.
  logic [N-1:0] mq [0:DB];
  logic [N-1:0] m_deb, m_rise, m_fall, m_busy, m_rpt;
  logic         m_flip;
`ifdef AUTOREPEAT_EN
  int           m_age   [N];
  bit           m_armed [N];
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= DB; k++) mq[k] = '0;
      m_deb = '0; m_rise = '0; m_fall = '0; m_busy = '0; m_rpt = '0;
`ifdef AUTOREPEAT_EN
      for (int c = 0; c < N; c++) begin m_age[c] = 0; m_armed[c] = 1'b0; end
`endif
    end else begin
      for (int c = 0; c < N; c++) begin
        m_flip = 1'b1;
        for (int k = 1; k <= DB; k++) if (mq[k][c] == m_deb[c]) m_flip = 1'b0;
        m_rise[c] = m_flip & ~m_deb[c];
        m_fall[c] = m_flip & m_deb[c];
        m_deb[c]  = m_deb[c] ^ m_flip;
        m_busy[c] = (mq[1][c] != m_deb[c]);
        m_rpt[c]  = 1'b0;
`ifdef AUTOREPEAT_EN
        if (m_rise[c]) begin
          m_armed[c] = 1'b1;
          m_age[c]   = 0;
        end else if (m_fall[c]) begin
          m_armed[c] = 1'b0;
        end else if (m_armed[c]) begin
          m_age[c]++;
          m_rpt[c] = (m_age[c] >= RD) && (((m_age[c] - RD) % RP) == 0);
        end
`endif
      end
      for (int k = DB; k > 0; k--) mq[k] = mq[k-1];
      mq[0] = undeb;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int cnt_a, cnt_b, at;
  int rpt_pos [$];

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (cmp_en) begin
          chk("cyc_deb",  32'(deb),  32'(m_deb));
          chk("cyc_rise", 32'(rise), 32'(m_rise));
          chk("cyc_fall", 32'(fall), 32'(m_fall));
          chk("cyc_busy", 32'(busy), 32'(m_busy));
          chk("cyc_rpt",  32'(rpt),  32'(m_rpt));
        end
      end
    join_none

    // Reset held with all inputs high, then release.
    rst_n = 1'b0;
    undeb = 4'hF;
    repeat (3) tick();
    cmp_en = 1'b1;
    chk("rst_deb",  32'(deb),  32'h0);
    chk("rst_rise", 32'(rise), 32'h0);
    chk("rst_fall", 32'(fall), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rpt",  32'(rpt),  32'h0);
    rst_n = 1'b1;
    repeat (5) tick();
    chk("rel_edge5_deb",   32'(deb),   32'h0);
    chk("rel_edge5_model", 32'(m_deb), 32'h0);
    tick();
    chk("rel_edge6_deb",   32'(deb),   32'hF);
    chk("rel_edge6_rise",  32'(rise),  32'hF);
    chk("rel_edge6_model", 32'(m_deb), 32'hF);
    tick();
    chk("rel_edge7_rise", 32'(rise), 32'h0);

    // Clean press then release on channel 0.
    undeb = 4'h0;
    repeat (10) tick();
    chk("all_low_deb", 32'(deb), 32'h0);
    undeb = 4'b0001;
    repeat (5) tick();
    chk("press_edge5_deb", 32'(deb), 32'h0);
    tick();
    chk("press_edge6_deb",  32'(deb),  32'h1);
    chk("press_edge6_rise", 32'(rise), 32'h1);
    cnt_a = 0;
    repeat (14) begin tick(); if (rise[0]) cnt_a++; end
    chk("press_single_rise", 32'(cnt_a), 32'd0);
    undeb = 4'h0;
    repeat (5) tick();
    chk("rel_edge5_deb0", 32'(deb[0]), 32'h1);
    tick();
    chk("rel_edge6_deb0", 32'(deb[0]), 32'h0);
    chk("rel_edge6_fall", 32'(fall),   32'h1);
    tick();
    chk("rel_edge7_fall", 32'(fall), 32'h0);

    // Bounce on channel 1 (2-cycle runs), then settle high.
    cnt_a = 0; cnt_b = 0;
    for (int c = 0; c < 20; c++) begin
      undeb[1] = ((c / 2) % 2 == 0);
      tick();
      if (busy[1]) cnt_a++;
      if (deb[1]) cnt_b++;
    end
    undeb[1] = 1'b1;
    at = 0; cnt_b = cnt_b;
    begin
      int nr;
      nr = 0;
      for (int k = 1; k <= 10; k++) begin
        tick();
        if (rise[1]) begin nr++; if (at == 0) at = k; end
        if (k < 6 && deb[1]) cnt_b++;
      end
      chk("bounce_busy_seen", 32'(cnt_a > 0), 32'h1);
      chk("bounce_deb_low",   32'(cnt_b),     32'd0);
      chk("bounce_rise_at",   32'(at),        32'd6);
      chk("bounce_rise_once", 32'(nr),        32'd1);
    end

    // Three-cycle glitch on channel 2.
    undeb[2] = 1'b1;
    cnt_b = 0;
    repeat (3) begin tick(); if (busy[2]) cnt_b++; end
    undeb[2] = 1'b0;
    cnt_a = 0;
    repeat (10) begin
      tick();
      if (busy[2]) cnt_b++;
      if (rise[2] | fall[2] | deb[2]) cnt_a++;
    end
    chk("glitch_no_edge",  32'(cnt_a),     32'd0);
    chk("glitch_busy_hit", 32'(cnt_b > 0), 32'h1);
    chk("glitch_busy_end", 32'(busy[2]),   32'h0);

    // Simultaneous fall on ch3 and rise on ch2.
    undeb[3] = 1'b1;
    repeat (8) tick();
    chk("sim_pre_deb3", 32'(deb[3]), 32'h1);
    undeb[3] = 1'b0;
    undeb[2] = 1'b1;
    repeat (6) tick();
    chk("sim_fall", 32'(fall), 32'h8);
    chk("sim_rise", 32'(rise), 32'h4);
    tick();
    chk("sim_deb", 32'(deb), 32'h6);

    // Reset in the middle of a count on ch0.
    undeb = 4'h0;
    repeat (10) tick();
    undeb = 4'b0001;
    cnt_a = 0;
    for (int k = 0; k < 10 && cnt_a < 2; k++) begin
      tick();
      if (busy[0]) cnt_a++; else cnt_a = 0;
    end
    chk("mid_busy_two", 32'(cnt_a), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_deb",  32'(deb),  32'h0);
    undeb = 4'h0;
    repeat (2) tick();
    rst_n = 1'b1;
    cnt_a = 0;
    repeat (10) begin tick(); if ((rise | fall) != 0) cnt_a++; end
    chk("mid_no_spurious", 32'(cnt_a), 32'd0);

    // Long hold on ch0: auto-repeat pulses when enabled.
    undeb = 4'b0001;
    at = 0;
    for (int k = 1; k <= 10 && at == 0; k++) begin
      tick();
      if (rise[0]) at = k;
    end
    chk("hold_rise_at", 32'(at), 32'd6);
    rpt_pos.delete();
    for (int k = 1; k <= 22; k++) begin
      tick();
      if (rpt[0]) rpt_pos.push_back(k);
    end
`ifdef AUTOREPEAT_EN
    chk("rpt_count", 32'(rpt_pos.size()), 32'd3);
    if (rpt_pos.size() == 3) begin
      chk("rpt_first",  32'(rpt_pos[0]), 32'd10);
      chk("rpt_second", 32'(rpt_pos[1]), 32'd15);
      chk("rpt_third",  32'(rpt_pos[2]), 32'd20);
    end
`else
    chk("rpt_count", 32'(rpt_pos.size()), 32'd0);
`endif
    undeb = 4'h0;
    repeat (10) tick();
    chk("end_deb", 32'(deb), 32'h0);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/debounce_bank.md
Name: debounce_bank

Overview:
- Parametrised multi-channel successor to the single-input button debouncer.
- Takes N_CH raw asynchronous inputs (buttons/switches) and synchronises each with a 2-FF chain.
- Filters each channel with its own stability counter and outputs a debounced level plus one-cycle rise/fall pulses per channel.
- Sits between board pins and the calculator control FSM, replacing per-button debounce instances.

Parameters:
- N_CH, 4: number of independent channels.
- DB_CYCLES, 100000: consecutive stable cycles needed to accept a new level (1 ms at 100 MHz); legal range >= 1.
- CNT_W, $clog2(DB_CYCLES+1): stability counter width per channel.
- INIT_LEVEL, 0: reset value of synchroniser flops and debounced level (all channels).
- REPEAT_DELAY, 50000000: cycles from accepted press to first repeat pulse (optional feature only).
- REPEAT_PERIOD, 10000000: cycles between subsequent repeat pulses (optional feature only).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- undeb  in  N_CH  raw, bouncing, asynchronous inputs.
- deb  out  N_CH  debounced level, registered.
- rise  out  N_CH  one-cycle pulse when deb[i] goes 0->1.
- fall  out  N_CH  one-cycle pulse when deb[i] goes 1->0.
- busy  out  N_CH  high while channel counter is non-zero (mismatch being timed).
- rpt  out  N_CH  auto-repeat pulse; constant 0 without AUTOREPEAT_EN.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - sync flops and deb = {N_CH{INIT_LEVEL}}.
  - Counters = 0; rise, fall and rpt = 0.
  - busy = 0, since it derives from the counters.
  - The same applies mid-operation: in-flight counts are discarded.
- Synchroniser: s1 <= undeb; s2 <= s1 per channel. Only s2 feeds the filter.
- Per-channel filter, evaluated every clock:
  - s2 == deb: cnt <= 0, which covers any bounce back to the current level.
  - s2 != deb and cnt < DB_CYCLES-1: cnt <= cnt+1.
  - s2 != deb and cnt == DB_CYCLES-1: deb <= s2, cnt <= 0. rise or fall is asserted in the same cycle deb first shows the new level, for exactly one cycle.
- Latency: a raw level held stable appears on deb DB_CYCLES+2 rising edges after the first edge that samples it. That is 2 sync stages plus DB_CYCLES filter edges.
- Any mismatch gap (s2 returns to deb) restarts the count from 0, so no partial credit is kept.
- The counter never exceeds DB_CYCLES-1, so there is no wrap-around.
- rise and fall are never both high on one channel in the same cycle. Channels are fully independent; any combination of channels may pulse in the same cycle.
- busy[i] = (cnt[i] != 0), combinational from the registered counter.
- DB_CYCLES=1: any single mismatched s2 sample is accepted on the next edge.

Optional Feature:
- Macro AUTOREPEAT_EN.
- Defined:
  - A per-channel repeat counter starts on rise[i]. rpt[i] pulses for one cycle REPEAT_DELAY cycles after rise[i], then every REPEAT_PERIOD cycles while deb[i]=1.
  - The counter clears and rpt stops on deb[i]=0 or reset.
  - rpt never coincides with rise.
- Not defined: no repeat counters are built and rpt is tied to 0.

Test Plan (N_CH=4, DB_CYCLES=4, INIT_LEVEL=0, REPEAT_DELAY=10, REPEAT_PERIOD=5):
- Reset: hold rst_n=0 with undeb=4'hF -> deb=0, rise=fall=busy=rpt=0. Release -> deb=4'hF after 6 edges, with rise=4'hF for one cycle.
- Clean press then release: undeb[0] 0->1 held 20 cycles then 0 -> deb[0] rises on edge 6 with a single rise[0] pulse. After release, deb[0] falls 6 edges later with a single fall[0] pulse.
- Bounce then settle:
  - Stimulus: undeb[1] toggles every 2 cycles for 20 cycles, then stays 1.
  - Required: deb[1] stays 0 throughout the bounce, busy[1] is seen pulsing, and exactly one rise[1] occurs 6 edges after the last transition.
- Short glitch: undeb[2] high for 3 cycles only -> deb[2] stays 0, no rise or fall, and busy[2] returns to 0.
- Simultaneous channels: start with deb[3]=1. In one cycle set undeb[3]=0 and undeb[2]=1 -> fall[3] and rise[2] assert in the same cycle, with no cross-channel effect.
- Reset mid-count: start a press on ch0, assert rst_n=0 after busy[0] has been high 2 cycles -> cnt=0 and deb=0 immediately, with no spurious pulse after release. With AUTOREPEAT_EN, holding undeb[0] gives rpt[0] pulses at 10, 15 and 20 cycles after rise[0].
